// File: rtl/vga_timing_pkg.sv
// Standard 640x480@60 raster constants and the pixel/sync types shared by the
// scan driver and its delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Sync flags are kept active-high so a cleared pipeline means "no sync".
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_t;

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register that realigns raster control bits with the
// PPU's pixel pipeline. DEPTH=0 collapses to a plain wire.
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset, en_i};
        assign q_o       = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // NOTE: this small storage array is reset on purpose; stale sync bits
        // left over from before reset would otherwise reach the pins.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_driver.sv
// Raster scan generator for the PPU: produces hcount/vcount, realigns sync and
// blank with the PPU pipeline, registers the returned colour onto the VGA pins.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 0,
    parameter int H_ACT      = H_ACTIVE,
    parameter int H_FRONT    = H_FP,
    parameter int H_SYN      = H_SYNC,
    parameter int H_BACK     = H_BP,
    parameter int V_ACT      = V_ACTIVE,
    parameter int V_FRONT    = V_FP,
    parameter int V_SYN      = V_SYNC,
    parameter int V_BACK     = V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_n,
    output logic        VGA_SYNC_n,
    output logic        VGA_CLK,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOT = H_ACT + H_FRONT + H_SYN + H_BACK;
    localparam int V_TOT = V_ACT + V_FRONT + V_SYN + V_BACK;

    localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
    localparam logic [9:0] H_ACT_END   = 10'(H_ACT);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACT + H_FRONT);
    localparam logic [9:0] H_SYNC_END  = 10'(H_ACT + H_FRONT + H_SYN);
    localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
    localparam logic [9:0] V_ACT_END   = 10'(V_ACT);
    localparam logic [9:0] V_ACT_LAST  = 10'(V_ACT - 1);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACT + V_FRONT);
    localparam logic [9:0] V_SYNC_END  = 10'(V_ACT + V_FRONT + V_SYN);
    localparam logic [1:0] DIV_LAST    = 2'(CLK_DIV - 1);

    logic [1:0] div_q, div_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       tick;
    logic       vga_clk_d;

    rgb_t       rgb_q;
    logic       hs_q, vs_q, blank_n_q;
    logic       vblank_q, fs_q, vga_clk_q;

    sync_t      raw, dly;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        div_d = tick ? 2'd0 : div_q + 2'd1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // With a 1:1 divider the DAC is clocked from clk directly, so the pin stays low.
    if (CLK_DIV == 1) begin : g_clk_tied
        assign vga_clk_d = 1'b0;
    end else begin : g_clk_div
        localparam logic [1:0] DIV_HALF = 2'(CLK_DIV / 2);
        assign vga_clk_d = (div_d >= DIV_HALF);
    end

    assign raw.hsync  = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
    assign raw.vsync  = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
    assign raw.active = (h_q < H_ACT_END) && (v_q < V_ACT_END);

    sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH ($bits(sync_t))
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en_i  (tick),
        .d_i   (raw),
        .q_o   (dly)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vblank_q  <= 1'b0;
            fs_q      <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            vga_clk_q <= vga_clk_d;
            fs_q      <= tick && (h_q == H_LAST) && (v_q == V_ACT_LAST);
            if (tick) begin
                hs_q      <= ~dly.hsync;
                vs_q      <= ~dly.vsync;
                blank_n_q <= dly.active;
                rgb_q     <= dly.active ? rgb_t'(rgb_in) : '0;
                vblank_q  <= (v_d >= V_ACT_END);
            end
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_n = blank_n_q;
    assign VGA_SYNC_n  = 1'b0;
    assign VGA_CLK     = vga_clk_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench: four scan drivers (full 640x480 timing plus reduced rasters
// with other dividers/pipeline depths) checked every clock against a tick-count model.
module tb_vga_scan_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        sy;
        logic        vclk;
        logic        vb;
        logic        fs;
    } pins_t;

    function automatic pins_t reset_pins();
        pins_t p;
        p      = '0;
        p.hs   = 1'b1;
        p.vs   = 1'b1;
        return p;
    endfunction

    function automatic string fmt(input pins_t p);
        return $sformatf("h=%0d v=%0d rgb=%06h hs=%b vs=%b blank_n=%b sync_n=%b vclk=%b vblank=%b fs=%b",
                         p.h, p.v, p.rgb, p.hs, p.vs, p.bl, p.sy, p.vclk, p.vb, p.fs);
    endfunction

    task automatic check_pins(input string name, input pins_t act, input pins_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got {%s} want {%s}", name, $time, fmt(act), fmt(exp));
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int DIV = (g == 0) ? 2   : (g == 1) ? 3  : (g == 2) ? 1 : 4;
        localparam int DLY = (g == 0) ? 0   : (g == 1) ? 2  : (g == 2) ? 3 : 1;
        localparam int HA  = (g == 0) ? 640 : (g == 1) ? 20 : (g == 2) ? 8 : 16;
        localparam int HF  = (g == 0) ? 16  : (g == 1) ? 4  : (g == 2) ? 2 : 3;
        localparam int HW  = (g == 0) ? 96  : (g == 1) ? 6  : (g == 2) ? 3 : 4;
        localparam int HB  = (g == 0) ? 48  : (g == 1) ? 5  : (g == 2) ? 2 : 3;
        localparam int VA  = (g == 0) ? 480 : (g == 1) ? 12 : (g == 2) ? 5 : 6;
        localparam int VF  = (g == 0) ? 10  : (g == 1) ? 2  : (g == 2) ? 1 : 1;
        localparam int VW  = (g == 0) ? 2   : (g == 1) ? 2  : (g == 2) ? 2 : 1;
        localparam int VB  = (g == 0) ? 33  : (g == 1) ? 3  : (g == 2) ? 2 : 2;
        localparam int HT  = HA + HF + HW + HB;
        localparam int VT  = VA + VF + VW + VB;

        logic [23:0] rgb_drv;
        logic [9:0]  hc, vc;
        logic [7:0]  r, gr, b;
        logic        hs, vs, bl, sy, vclk, vb, fs;
        pins_t       dut_pins;
        pins_t       exp_q [$];

        if (g == 0) begin : g_dut
            vga_scan_driver u_dut (
                .clk(clk), .reset(reset), .rgb_in(rgb_drv),
                .hcount(hc), .vcount(vc), .VGA_R(r), .VGA_G(gr), .VGA_B(b),
                .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_n(bl), .VGA_SYNC_n(sy),
                .VGA_CLK(vclk), .vblank(vb), .frame_start(fs)
            );
        end else begin : g_dut
            vga_scan_driver #(
                .CLK_DIV(DIV), .PIPE_DELAY(DLY),
                .H_ACT(HA), .H_FRONT(HF), .H_SYN(HW), .H_BACK(HB),
                .V_ACT(VA), .V_FRONT(VF), .V_SYN(VW), .V_BACK(VB)
            ) u_dut (
                .clk(clk), .reset(reset), .rgb_in(rgb_drv),
                .hcount(hc), .vcount(vc), .VGA_R(r), .VGA_G(gr), .VGA_B(b),
                .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_n(bl), .VGA_SYNC_n(sy),
                .VGA_CLK(vclk), .vblank(vb), .frame_start(fs)
            );
        end

        assign dut_pins = {hc, vc, r, gr, b, hs, vs, bl, sy, vclk, vb, fs};

        // Colour source: random, with frequent full-white to exercise blanking.
        initial begin : drive_rgb
            rgb_drv = '0;
            forever begin
                @(posedge clk);
                #2;
                rgb_drv = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
            end
        end

        // Reference: position after n ticks is (n mod HT, (n div HT) mod VT);
        // the pins after tick n show position n-1-DLY and the colour sampled at tick n.
        initial begin : model
            int    c, n, m, mh, mv;
            pins_t st;
            c  = 0;
            n  = 0;
            st = reset_pins();
            forever begin
                @(posedge clk);
                if (reset) begin
                    c  = 0;
                    n  = 0;
                    st = reset_pins();
                end else begin
                    c++;
                    st.fs = 1'b0;
                    if (c % DIV == 0) begin
                        n++;
                        m = n - 1 - DLY;
                        if (m >= 0) begin
                            mh    = m % HT;
                            mv    = (m / HT) % VT;
                            st.hs = !(mh >= HA + HF && mh < HA + HF + HW);
                            st.vs = !(mv >= VA + VF && mv < VA + VF + VW);
                            st.bl = (mh < HA) && (mv < VA);
                            st.rgb = st.bl ? rgb_drv : 24'h0;
                        end
                        st.fs = (n % HT == 0) && ((n / HT) % VT == VA);
                    end
                    st.h    = 10'(n % HT);
                    st.v    = 10'((n / HT) % VT);
                    st.vb   = ((n / HT) % VT) >= VA;
                    st.vclk = (DIV > 1) && ((c % DIV) >= DIV / 2);
                end
                exp_q.push_back(st);
            end
        end

        initial begin : monitor
            pins_t exp;
            int    hs_run, vs_run;
            hs_run = 0;
            vs_run = 0;
            forever begin
                @(negedge clk);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    if (reset) exp = reset_pins();
                    check_pins($sformatf("cfg%0d_pins", g), dut_pins, exp);
                end
                if (reset) begin
                    hs_run = 0;
                    vs_run = 0;
                end else begin
                    if (!hs) hs_run++;
                    else if (hs_run > 0) begin
                        check($sformatf("cfg%0d_hsync_width_clk", g), hs_run, HW * DIV);
                        hs_run = 0;
                    end
                    if (!vs) vs_run++;
                    else if (vs_run > 0) begin
                        check($sformatf("cfg%0d_vsync_width_clk", g), vs_run, VW * HT * DIV);
                        vs_run = 0;
                    end
                end
            end
        end
    end

    initial begin : main
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        // 8600 clocks put the full-timing driver at line 5, column 300.
        repeat (8600) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (30000) @(posedge clk);
        #2 reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 reset = 1'b0;
        repeat (20000) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
